// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencing controller.
package systolic_pkg;

    localparam int DATAWIDTH_DEF  = 16;
    localparam int N_SIZE_DEF     = 3;

    // Cycles during which skewed operands are still entering the array edges
    localparam int FEED_CYCLES    = 2 * N_SIZE_DEF - 1;
    // Cycles until the bottom-right PE has absorbed its last product
    localparam int COMPUTE_CYCLES = 3 * N_SIZE_DEF - 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DONE
    } ctrl_state_t;

    typedef logic [DATAWIDTH_DEF-1:0] operand_t;

    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int compute_cycles(input int n);
        return 3 * n - 2;
    endfunction

    // Compute counter must hold 0..3n-2 so the final increment never wraps
    function automatic int cnt_width(input int n);
        return $clog2(3 * n - 1);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Operand buffers for A and B plus the registered, diagonally skewed edge drivers.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 3,
    parameter int TW        = 3,
    parameter int KW        = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [KW-1:0]               wr_beat,
    input  logic [N_SIZE*DATAWIDTH-1:0] a_col_in,
    input  logic [N_SIZE*DATAWIDTH-1:0] b_row_in,
    input  logic                        feed_en,
    input  logic [TW-1:0]               t_next,
    output logic [N_SIZE*DATAWIDTH-1:0] a_edge,
    output logic [N_SIZE*DATAWIDTH-1:0] b_edge
);

    localparam int FEED = feed_cycles(N_SIZE);

    logic [DATAWIDTH-1:0]        a_buf [N_SIZE][N_SIZE];
    logic [DATAWIDTH-1:0]        b_buf [N_SIZE][N_SIZE];
    logic [N_SIZE*DATAWIDTH-1:0] a_next;
    logic [N_SIZE*DATAWIDTH-1:0] b_next;

    // Beat k carries column k of A and row k of B; buffers carry no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < N_SIZE; i++) begin
                a_buf[i][wr_beat] <= a_col_in[i*DATAWIDTH +: DATAWIDTH];
                b_buf[wr_beat][i] <= b_row_in[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Row i of A and column j of B enter delayed by i and j cycles respectively
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (feed_en && (int'(t_next) < FEED)) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int k = 0; k < N_SIZE; k++) begin
                    if (int'(t_next) == i + k) begin
                        a_next[i*DATAWIDTH +: DATAWIDTH] = a_buf[i][k];
                        b_next[i*DATAWIDTH +: DATAWIDTH] = b_buf[k][i];
                    end
                end
            end
        end
    end

    // Edges are registered so the array sees stable operands for a full cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_edge <= '0;
            b_edge <= '0;
        end else begin
            a_edge <= a_next;
            b_edge <= b_next;
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the output-stationary systolic multiplier array.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_SIZE*DATAWIDTH-1:0] a_col_in,
    input  logic [N_SIZE*DATAWIDTH-1:0] b_row_in,
    output logic [N_SIZE*DATAWIDTH-1:0] a_edge,
    output logic [N_SIZE*DATAWIDTH-1:0] b_edge,
    output logic                        pe_rst_n,
    output logic                        busy,
    output logic                        done,
    output logic                        result_valid
);

    localparam int TW     = cnt_width(N_SIZE);
    localparam int KW     = $clog2(N_SIZE);
    localparam int LAST_T = compute_cycles(N_SIZE) - 1;

    ctrl_state_t   state;
    ctrl_state_t   next_state;
    logic [TW-1:0] t;
    logic [TW-1:0] t_next;
    logic [KW-1:0] beat;
    logic          accept;
    logic          feed_en;
    logic          in_ready_d;
    logic          busy_d;
    logic          done_d;
    logic          pe_rst_n_d;
    logic          result_valid_d;

    assign accept  = in_valid && in_ready;
    assign t_next  = (state == COMPUTE) ? t + TW'(1) : '0;
    assign feed_en = (next_state == COMPUTE);

    // State, compute counter and load beat index
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
            beat  <= '0;
        end else begin
            state <= next_state;
            t     <= t_next;
            if (state != LOAD) begin
                beat <= '0;
            end else if (accept) begin
                beat <= beat + KW'(1);
            end
        end
    end

    // Job sequencing; start is only honoured from IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (accept && (beat == KW'(N_SIZE - 1))) next_state = COMPUTE;
            COMPUTE: if (t == TW'(LAST_T)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered status outputs, derived from the upcoming state
    always_comb begin
        in_ready_d     = (next_state == LOAD);
        busy_d         = (next_state != IDLE);
        done_d         = (next_state == DONE);
        pe_rst_n_d     = !((state == IDLE) && start);
        result_valid_d = result_valid;
        if (next_state == DONE) begin
            result_valid_d = 1'b1;
        end
        if ((state == IDLE) && start) begin
            result_valid_d = 1'b0;
        end
    end

    // Status output registers; reset also holds the PE array cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pe_rst_n     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            in_ready     <= in_ready_d;
            busy         <= busy_d;
            done         <= done_d;
            pe_rst_n     <= pe_rst_n_d;
            result_valid <= result_valid_d;
        end
    end

    systolic_skew_feeder #(
        .DATAWIDTH(DATAWIDTH),
        .N_SIZE   (N_SIZE),
        .TW       (TW),
        .KW       (KW)
    ) u_feeder (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_beat (beat),
        .a_col_in(a_col_in),
        .b_row_in(b_row_in),
        .feed_en (feed_en),
        .t_next  (t_next),
        .a_edge  (a_edge),
        .b_edge  (b_edge)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench: drives jobs into systolic_ctrl and models the PE array it feeds.
`timescale 1ns/1ps
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N    = N_SIZE_DEF;
    localparam int DW   = DATAWIDTH_DEF;
    localparam int HIST = 64;
    localparam int LOAD_LAT = 1 + N;

    typedef operand_t mat_t [N][N];
    typedef logic [2*DW-1:0] acc_t;
    typedef acc_t cmat_t [N][N];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*DW-1:0] a_col_in = '0;
    logic [N*DW-1:0] b_row_in = '0;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;
    logic          pe_rst_n;
    logic          busy;
    logic          done;
    logic          result_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [N*DW-1:0] ae_hist [HIST];
    logic [N*DW-1:0] be_hist [HIST];
    logic busy_hist [HIST];
    logic ir_hist   [HIST];
    logic pe_hist   [HIST];
    logic rv_hist   [HIST];
    int   done_at;
    int   done_cnt;

    acc_t     c_arr [N][N];
    operand_t a_sh  [N][N];
    operand_t b_sh  [N][N];

    systolic_ctrl #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_col_in    (a_col_in),
        .b_row_in    (b_row_in),
        .a_edge      (a_edge),
        .b_edge      (b_edge),
        .pe_rst_n    (pe_rst_n),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    function automatic operand_t pe_a(input int i, input int j);
        if (j == 0) return a_edge[i*DW +: DW];
        return a_sh[i][j-1];
    endfunction

    function automatic operand_t pe_b(input int i, input int j);
        if (i == 0) return b_edge[j*DW +: DW];
        return b_sh[i-1][j];
    endfunction

    // Behavioural output-stationary array: A flows right, B flows down, C accumulates
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_rst_n !== 1'b1) begin
                    c_arr[i][j] <= '0;
                    a_sh[i][j]  <= '0;
                    b_sh[i][j]  <= '0;
                end else begin
                    c_arr[i][j] <= c_arr[i][j] + acc_t'(pe_a(i, j)) * acc_t'(pe_b(i, j));
                    a_sh[i][j]  <= pe_a(i, j);
                    b_sh[i][j]  <= pe_b(i, j);
                end
            end
        end
    end

    function automatic cmat_t matmul(input mat_t a, input mat_t b);
        cmat_t c;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < N; k++) c[i][j] += acc_t'(a[i][k]) * acc_t'(b[k][j]);
            end
        end
        return c;
    endfunction

    function automatic logic [N*DW-1:0] exp_a_edge(input mat_t a, input int t);
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = a[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b_edge(input mat_t b, input int t);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = b[t-j][j];
        return v;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = operand_t'($urandom);
        return m;
    endfunction

    function automatic mat_t scaled_ident(input int s);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = (i == j) ? operand_t'(s) : '0;
        return m;
    endfunction

    // Runs one job starting at cycle 0 and records outputs per cycle; never compares
    task automatic run_job(input mat_t a, input mat_t b, input int stall,
                           input logic [HIST-1:0] start_mask, input bit junk,
                           input int abort_cyc, input int max_cyc);
        int k = 0;
        int stall_left = 0;
        bit hs;
        done_at  = -1;
        done_cnt = 0;
        for (int c = 0; c < HIST; c++) begin
            ae_hist[c] = 'x; be_hist[c] = 'x; busy_hist[c] = 1'bx;
            ir_hist[c] = 1'bx; pe_hist[c] = 1'bx; rv_hist[c] = 1'bx;
        end
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_col_in[i*DW +: DW] = a[i][0];
            b_row_in[i*DW +: DW] = b[0][i];
        end
        for (int cyc = 0; cyc < max_cyc && cyc < HIST; cyc++) begin
            @(negedge clk);
            ae_hist[cyc] = a_edge;  be_hist[cyc] = b_edge;
            busy_hist[cyc] = busy;  ir_hist[cyc] = in_ready;
            pe_hist[cyc] = pe_rst_n; rv_hist[cyc] = result_valid;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            hs = in_valid && (in_ready === 1'b1);
            @(posedge clk); #1;
            if (done_at >= 0 && cyc >= done_at + 3) break;
            start = start_mask[cyc+1];
            rst   = (cyc + 1 == abort_cyc);
            if (hs) begin
                k++;
                if (k == 1) stall_left = stall;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            if (k < N) begin
                in_valid = (stall_left == 0);
                for (int i = 0; i < N; i++) begin
                    a_col_in[i*DW +: DW] = a[i][k];
                    b_row_in[i*DW +: DW] = b[k][i];
                end
            end else if (junk) begin
                in_valid = 1'b1;
                a_col_in = {N{operand_t'($urandom)}};
                b_row_in = {N{operand_t'($urandom)}};
            end else begin
                in_valid = 1'b0;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        vectors++; if (a_edge !== '0) begin miscompares++; $display("[TB] FAIL reset_a_edge got %h want 0", a_edge); end
        vectors++; if (b_edge !== '0) begin miscompares++; $display("[TB] FAIL reset_b_edge got %h want 0", b_edge); end
        vectors++; if (pe_rst_n !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pe_rst_n got %b want 0", pe_rst_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_result_valid got %b want 0", result_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_identity(input mat_t a);
        int done_exp = LOAD_LAT + COMPUTE_CYCLES;
        run_job(a, scaled_ident(1), 0, '0, 1'b0, -1, 40);
        vectors++; if (done_at != done_exp) begin miscompares++; $display("[TB] FAIL ident_done_cycle got %0d want %0d", done_at, done_exp); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL ident_done_count got %0d want 1", done_cnt); end
        for (int c = 0; c <= done_exp + 2; c++) begin
            vectors++;
            if (busy_hist[c] !== (c >= 1 && c <= done_exp)) begin
                miscompares++; $display("[TB] FAIL ident_busy cycle %0d got %b want %b", c, busy_hist[c], (c >= 1 && c <= done_exp));
            end
        end
        for (int t = 0; t <= COMPUTE_CYCLES; t++) begin
            vectors++;
            if (ae_hist[LOAD_LAT+t] !== exp_a_edge(a, t)) begin
                miscompares++; $display("[TB] FAIL ident_a_edge t=%0d got %h want %h", t, ae_hist[LOAD_LAT+t], exp_a_edge(a, t));
            end
            vectors++;
            if (be_hist[LOAD_LAT+t] !== exp_b_edge(scaled_ident(1), t)) begin
                miscompares++; $display("[TB] FAIL ident_b_edge t=%0d got %h want %h", t, be_hist[LOAD_LAT+t], exp_b_edge(scaled_ident(1), t));
            end
        end
        vectors++; if (ae_hist[LOAD_LAT+2][2*DW +: DW] !== 16'd7) begin miscompares++; $display("[TB] FAIL ident_a_edge2_t2 got %0d want 7", ae_hist[LOAD_LAT+2][2*DW +: DW]); end
        vectors++; if (rv_hist[done_exp] !== 1'b1) begin miscompares++; $display("[TB] FAIL ident_rv_at_done got %b want 1", rv_hist[done_exp]); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_arr[i][j] !== acc_t'(a[i][j])) begin
                    miscompares++; $display("[TB] FAIL ident_C[%0d][%0d] got %0d want %0d", i, j, c_arr[i][j], a[i][j]);
                end
            end
    endtask

    task automatic test_full_product(input mat_t a);
        mat_t b = '{'{16'd9, 16'd8, 16'd7}, '{16'd6, 16'd5, 16'd4}, '{16'd3, 16'd2, 16'd1}};
        int exp_c [N][N] = '{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}};
        run_job(a, b, 0, '0, 1'b0, -1, 40);
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL full_result_valid got %b want 1", result_valid); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_arr[i][j] !== acc_t'(exp_c[i][j])) begin
                    miscompares++; $display("[TB] FAIL full_C[%0d][%0d] got %0d want %0d", i, j, c_arr[i][j], exp_c[i][j]);
                end
            end
    endtask

    task automatic test_load_stall();
        mat_t a = rand_mat();
        mat_t b = rand_mat();
        cmat_t ref_c = matmul(a, b);
        int done_exp = LOAD_LAT + COMPUTE_CYCLES + 4;
        run_job(a, b, 4, '0, 1'b0, -1, 40);
        for (int c = 2; c <= 5; c++) begin
            vectors++; if (ir_hist[c] !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_in_ready cycle %0d got %b want 1", c, ir_hist[c]); end
            vectors++; if (busy_hist[c] !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_busy cycle %0d got %b want 1", c, busy_hist[c]); end
        end
        vectors++; if (done_at != done_exp) begin miscompares++; $display("[TB] FAIL stall_done_cycle got %0d want %0d", done_at, done_exp); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_arr[i][j] !== ref_c[i][j]) begin
                    miscompares++; $display("[TB] FAIL stall_C[%0d][%0d] got %0d want %0d", i, j, c_arr[i][j], ref_c[i][j]);
                end
            end
    endtask

    task automatic test_start_while_busy();
        mat_t a = rand_mat();
        mat_t b = rand_mat();
        cmat_t ref_c = matmul(a, b);
        int done_exp = LOAD_LAT + COMPUTE_CYCLES;
        logic [HIST-1:0] mask = '0;
        mask[LOAD_LAT+2] = 1'b1;
        mask[done_exp]   = 1'b1;
        run_job(a, b, 0, mask, 1'b1, -1, 40);
        vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL busy_start_done_count got %0d want 1", done_cnt); end
        vectors++; if (done_at != done_exp) begin miscompares++; $display("[TB] FAIL busy_start_done_cycle got %0d want %0d", done_at, done_exp); end
        for (int c = done_exp + 1; c <= done_exp + 3; c++) begin
            vectors++; if (busy_hist[c] !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_start_restart cycle %0d busy got %b want 0", c, busy_hist[c]); end
            vectors++; if (ir_hist[c] !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_start_in_ready cycle %0d got %b want 0", c, ir_hist[c]); end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_arr[i][j] !== ref_c[i][j]) begin
                    miscompares++; $display("[TB] FAIL busy_start_C[%0d][%0d] got %0d want %0d", i, j, c_arr[i][j], ref_c[i][j]);
                end
            end
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_hold_result_valid got %b want 1", result_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_hold_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_compute();
        mat_t a = rand_mat();
        mat_t b = rand_mat();
        cmat_t ref_c;
        int abort = LOAD_LAT + 3;
        run_job(a, b, 0, '0, 1'b0, abort, LOAD_LAT + COMPUTE_CYCLES + 3);
        vectors++; if (ae_hist[abort+1] !== '0) begin miscompares++; $display("[TB] FAIL abort_a_edge got %h want 0", ae_hist[abort+1]); end
        vectors++; if (be_hist[abort+1] !== '0) begin miscompares++; $display("[TB] FAIL abort_b_edge got %h want 0", be_hist[abort+1]); end
        vectors++; if (pe_hist[abort+1] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_pe_rst_n got %b want 0", pe_hist[abort+1]); end
        vectors++; if (busy_hist[abort+1] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %b want 0", busy_hist[abort+1]); end
        vectors++; if (ir_hist[abort+1] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_in_ready got %b want 0", ir_hist[abort+1]); end
        vectors++; if (done_cnt != 0) begin miscompares++; $display("[TB] FAIL abort_done_count got %0d want 0", done_cnt); end
        a = rand_mat();
        b = rand_mat();
        ref_c = matmul(a, b);
        run_job(a, b, 0, '0, 1'b0, -1, 40);
        vectors++; if (done_at != LOAD_LAT + COMPUTE_CYCLES) begin miscompares++; $display("[TB] FAIL after_abort_done_cycle got %0d want %0d", done_at, LOAD_LAT + COMPUTE_CYCLES); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_arr[i][j] !== ref_c[i][j]) begin
                    miscompares++; $display("[TB] FAIL after_abort_C[%0d][%0d] got %0d want %0d", i, j, c_arr[i][j], ref_c[i][j]);
                end
            end
    endtask

    task automatic test_back_to_back(input mat_t a);
        int done_exp = LOAD_LAT + COMPUTE_CYCLES;
        run_job(a, scaled_ident(1), 0, '0, 1'b0, -1, 40);
        run_job(a, scaled_ident(2), 0, '0, 1'b0, -1, 40);
        vectors++; if (pe_hist[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_pe_rst_n_before got %b want 1", pe_hist[0]); end
        vectors++; if (pe_hist[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_pe_rst_n_clear got %b want 0", pe_hist[1]); end
        vectors++; if (pe_hist[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_pe_rst_n_after got %b want 1", pe_hist[2]); end
        vectors++; if (rv_hist[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rv_before got %b want 1", rv_hist[0]); end
        for (int c = 1; c < done_exp; c++) begin
            vectors++; if (rv_hist[c] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_rv_during cycle %0d got %b want 0", c, rv_hist[c]); end
        end
        vectors++; if (rv_hist[done_exp] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rv_done got %b want 1", rv_hist[done_exp]); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_arr[i][j] !== acc_t'(2 * a[i][j])) begin
                    miscompares++; $display("[TB] FAIL b2b_C[%0d][%0d] got %0d want %0d", i, j, c_arr[i][j], 2 * a[i][j]);
                end
            end
    endtask

    task automatic test_random_jobs();
        for (int n = 0; n < 4; n++) begin
            mat_t a = rand_mat();
            mat_t b = rand_mat();
            cmat_t ref_c = matmul(a, b);
            int stall = int'($urandom_range(0, 3));
            int t0 = LOAD_LAT + stall;
            run_job(a, b, stall, '0, 1'b0, -1, 40);
            vectors++; if (done_at != t0 + COMPUTE_CYCLES) begin miscompares++; $display("[TB] FAIL rand%0d_done_cycle got %0d want %0d", n, done_at, t0 + COMPUTE_CYCLES); end
            vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL rand%0d_done_count got %0d want 1", n, done_cnt); end
            for (int t = 0; t < FEED_CYCLES; t++) begin
                vectors++;
                if (ae_hist[t0+t] !== exp_a_edge(a, t) || be_hist[t0+t] !== exp_b_edge(b, t)) begin
                    miscompares++; $display("[TB] FAIL rand%0d_edges t=%0d got %h/%h want %h/%h", n, t, ae_hist[t0+t], be_hist[t0+t], exp_a_edge(a, t), exp_b_edge(b, t));
                end
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    vectors++;
                    if (c_arr[i][j] !== ref_c[i][j]) begin
                        miscompares++; $display("[TB] FAIL rand%0d_C[%0d][%0d] got %0d want %0d", n, i, j, c_arr[i][j], ref_c[i][j]);
                    end
                end
        end
    endtask

    // Hard stop in case the DUT or bench locks up
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        mat_t a1 = '{'{16'd1, 16'd2, 16'd3}, '{16'd4, 16'd5, 16'd6}, '{16'd7, 16'd8, 16'd9}};
        test_reset();
        test_identity(a1);
        test_full_product(a1);
        test_load_stall();
        test_start_while_busy();
        test_reset_mid_compute();
        test_back_to_back(a1);
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
